// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding, board defaults and baud divider helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_t;
  localparam int CLK_FREQ_DEF   = 100000000;
  localparam int BAUD_DEF       = 115200;
  localparam int OVERSAMPLE_DEF = 16;
  function automatic int baud_div(input int clk, input int baud, input int os);
    return clk / (baud * os);
  endfunction
endpackage

// File: rtl/uart_rx_fifo_ctrl_if.sv
// uart_rx_fifo_ctrl_if: received-byte stream, show-ahead data with valid/ready
interface uart_rx_fifo_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  modport master (output rx_data, rx_valid, input rx_ready);
  modport slave  (input rx_data, rx_valid, output rx_ready);
endinterface

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: show-ahead FIFO; a push into a full FIFO succeeds only alongside a pop
module uart_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty   = count == '0;
  assign full    = count == CW'(DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= din;
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      count  <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// uart_rx_fifo_ctrl: 8N1 oversampling UART receiver feeding a show-ahead byte FIFO
module uart_rx_fifo_ctrl import uart_pkg::*; #(
  parameter int CLK_FREQ   = CLK_FREQ_DEF,
  parameter int BAUD       = BAUD_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int FIFO_DEPTH = 4,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_pin_in,
  uart_rx_fifo_ctrl_if.master rx,
  output logic          frame_err,
  output logic          overrun,
  input  logic          clr_err,
  output logic          rx_busy,
  output logic [CW-1:0] fifo_count
);
  localparam int DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int DW  = $clog2(DIV + 1);
  localparam int OW  = $clog2(OVERSAMPLE);
  rx_state_t state, state_n;
  logic [1:0] sync;
  logic rx_s, tick, samp, start_det, push, pop, fe, full, empty;
  logic [DW-1:0] div_cnt;
  logic [OW-1:0] os_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg, head;
  assign rx_s      = sync[1];
  assign start_det = state == IDLE && !rx_s;
  assign tick      = div_cnt == DW'(DIV - 1);
  // START waits half a bit so every later sample lands mid-bit
  assign samp      = tick && os_cnt == (state == START ? OW'(OVERSAMPLE / 2 - 1) : OW'(OVERSAMPLE - 1));
  assign rx_busy   = state != IDLE;
  assign pop       = rx.rx_valid && rx.rx_ready;
  assign rx.rx_valid = !empty;
  assign rx.rx_data  = head;
  always_comb begin
    state_n = state;
    push    = 1'b0;
    fe      = 1'b0;
    case (state)
      IDLE:      state_n = rx_s ? IDLE : START;
      START:     state_n = !samp ? START : rx_s ? IDLE : DATA;
      DATA:      state_n = samp && bit_idx == 3'd7 ? STOP : DATA;
      STOP: begin
        push    = samp && rx_s;
        fe      = samp && !rx_s;
        state_n = !samp ? STOP : rx_s ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: state_n = rx_s ? IDLE : WAIT_IDLE;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync      <= 2'b11;
      state     <= IDLE;
      div_cnt   <= '0;
      os_cnt    <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sync      <= {sync[0], rx_pin_in};
      state     <= state_n;
      frame_err <= fe;
      div_cnt   <= start_det || tick ? '0 : div_cnt + 1'b1;
      if (start_det) os_cnt <= '0;
      else if (tick) os_cnt <= samp ? '0 : os_cnt + 1'b1;
      if (state == START) bit_idx <= '0;
      else if (state == DATA && samp) begin
        bit_idx <= bit_idx + 1'b1;
        shreg   <= {rx_s, shreg[7:1]};
      end
      // a simultaneous pop frees the slot, so only an unaided full push is an overrun
      overrun <= push && full && !pop ? 1'b1 : clr_err ? 1'b0 : overrun;
    end
  end
  uart_byte_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (shreg),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );
endmodule

// File: doc/uart_rx_fifo_ctrl.md
Name: uart_rx_fifo_ctrl

Overview:
- UART 8N1 receiver with 16x oversampling, glitch rejection and framing-error detection.
- Received bytes go into a small show-ahead byte FIFO drained with a valid/ready handshake.
- Receive-side counterpart of the board transmit path. Instantiated beside the UART top on the 100 MHz board clock to accept host commands on rx_pin_in.

Parameters:
- CLK_FREQ, 100000000, input clock frequency in Hz.
- BAUD, 115200, line bit rate.
- OVERSAMPLE, 16, ticks per bit; even, at least 4.
- FIFO_DEPTH, 4, byte entries; power of two, at least 2.

Ports:
- clk  input  1  system clock (CLK100MHZ at top level).
- rst_n  input  1  asynchronous active-low reset.
- rx_pin_in  input  1  asynchronous serial line, idle high.
- rx_data  output  8  FIFO head byte; valid only while rx_valid=1.
- rx_valid  output  1  FIFO non-empty.
- rx_ready  input  1  consumer accepts head byte this cycle.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- overrun  output  1  sticky; set when a good byte arrives while the FIFO is full.
- clr_err  input  1  synchronous clear of overrun.
- rx_busy  output  1  high in any state other than IDLE.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst_n=0, asynchronous) clears all state:
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, rx_busy=0, fifo_count=0.
  - Synchronizer flops preset to 1. FSM goes to IDLE.
- rx_pin_in passes through a 2-flop synchronizer. The FSM uses only the synchronized value rx_s.
- Tick divider:
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), truncated; 54 at defaults.
  - The counter runs 0..DIV-1 and issues a one-cycle tick when it reaches DIV-1.
  - Divider and oversample counter are cleared on start-edge detection.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: rx_s==0 moves to START and clears the counters.
  - START: after OVERSAMPLE/2 ticks, sample rx_s.
    - 0 moves to DATA with the bit index at 0.
    - 1 is treated as a glitch and returns to IDLE. Nothing is recorded.
  - DATA: every OVERSAMPLE ticks, sample one bit, LSB first, into a shift register. After bit 7, move to STOP.
  - STOP: after OVERSAMPLE ticks, sample rx_s.
    - 1: push the byte and return to IDLE.
    - 0: pulse frame_err for exactly one cycle, drop the byte, move to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1, then move to IDLE. This covers a break or a held-low line.
- FIFO behaviour:
  - Show-ahead: rx_data always equals the head entry. rx_valid = (fifo_count != 0).
  - Pop when rx_valid && rx_ready. Push happens on the stop-sample cycle with stop bit = 1.
  - A byte pushed into an empty FIFO appears on rx_data/rx_valid on the cycle after the stop-sample cycle (latency 1).
  - Push and pop in the same cycle: both succeed and count is unchanged. This includes the full case, so no overrun is flagged.
  - Push while full without a pop: byte dropped, overrun set to 1. FIFO contents are untouched.
  - rx_ready while empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- overrun clears on clr_err=1. If clr_err and a new overrun occur in the same cycle, set wins.
- Reset asserted mid-frame: the partial byte is discarded and the FIFO is emptied. After reset release, reception starts only on a fresh falling edge.

Decomposition:
- Package uart_pkg holds:
  - rx_state_t enum (IDLE, START, DATA, STOP, WAIT_IDLE).
  - Default constants CLK_FREQ_DEF, BAUD_DEF, OVERSAMPLE_DEF.
  - Function baud_div(clk, baud, os) returning DIV.
- One sub-module, uart_byte_fifo:
  - Parameterised by WIDTH=8 and DEPTH.
  - Ports: push/din, pop/dout show-ahead, full, empty, count; asynchronous active-low reset.
- The FSM, synchronizer and divider stay in the top module.

Test Plan:
- Defaults (864 clocks/bit), send 0xA5 with rx_ready=1 → rx_valid high for one cycle with rx_data=0xA5, one cycle after the stop-sample; frame_err=0, overrun=0.
- Line low for 300 clocks (< 432-clock half bit), then high → no push, rx_busy returns to 0, fifo_count=0.
- Send 0x3C with the stop bit driven low, hold low 2000 clocks, then send 0x5A → one frame_err pulse; no 0x3C delivered; 0x5A received correctly.
- rx_ready=0, send 0x01..0x05 back-to-back → fifo_count=4, overrun=1. Then rx_ready=1 → pops 0x01, 0x02, 0x03, 0x04 in order; 0x05 is lost. Pulse clr_err → overrun=0.
- FIFO full with rx_ready asserted exactly on the stop-sample cycle of a new byte → count stays 4, overrun stays 0, the new byte is delivered last.
- rst_n low for 10 clocks during bit 4 of 0x77, then send 0x99 → all outputs 0 during reset; only 0x99 is received afterwards.
